aes256_iter_ctrl: RTL

Iterative AES-256 encryption controller. It accepts one 128-bit block and a 256-bit key per transaction through a valid/ready handshake. It sequences the initial AddRoundKey, 13 full rounds and the final round, one round per clock, over a single shared round datapath and an on-the-fly 256-bit key-expansion step. It sits between the block-feeding logic and the ciphertext consumer, and replaces the fully unrolled single-cycle cipher wherever area matters more than throughput.

---
 rtl/aes256_iter_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aes256_iter_ctrl.sv
// Iterative AES-256 encryption controller. It runs one round per clock over a
// shared round datapath and expands the key schedule on the fly.
module aes256_iter_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [255:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned J_W    = 3;
  localparam int unsigned ROUNDS = 14;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   s_q, s_d;
  logic [KEY_W-1:0]   k_q, k_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic [J_W-1:0]     j_q, j_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [BLK_W-1:0]   sr_c;
  logic [BLK_W-1:0]   mc_c;
  logic [KEY_W-1:0]   kx_c;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Generic GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // SubBytes followed by ShiftRows; byte (row r, column c) sits at index 4c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        r[127-8*(4*c+rr) -: 8] = sbox(s[127-8*(4*((c+rr)%4)+rr) -: 8]);
      end
    end
    return r;
  endfunction

  // MixColumns with the circulant matrix {02 03 01 01} per 32-bit column.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  // Round constant; indices outside 1..7 cannot occur and yield zero.
  function automatic logic [7:0] rcon(input logic [2:0] j);
    logic [7:0] rc;
    case (j)
      3'd1:    rc = 8'h01;
      3'd2:    rc = 8'h02;
      3'd3:    rc = 8'h04;
      3'd4:    rc = 8'h08;
      3'd5:    rc = 8'h10;
      3'd6:    rc = 8'h20;
      3'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // One AES-256 key-schedule step producing the next eight words.
  function automatic logic [255:0] expand(input logic [255:0] k, input logic [2:0] j);
    logic [31:0] w [8];
    logic [31:0] n [8];
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    n[0] = sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon(j), 24'h000000} ^ w[0];
    n[1] = n[0] ^ w[1];
    n[2] = n[1] ^ w[2];
    n[3] = n[2] ^ w[3];
    n[4] = sub_word(n[3]) ^ w[4];
    n[5] = n[4] ^ w[5];
    n[6] = n[5] ^ w[6];
    n[7] = n[6] ^ w[7];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  // Shared round datapath and key step.
  assign sr_c = sub_shift(s_q);
  assign mc_c = mix_columns(sr_c);
  assign kx_c = expand(k_q, j_q);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      rnd_q       <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      rnd_q       <= rnd_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, round sequencing and registered-flag decode.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rnd_d   = rnd_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_data ^ key[255:128];
          k_d     = key;
          rnd_d   = RND_W'(1);
          j_d     = J_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (rnd_q == LAST_RND) begin
          s_d     = sr_c ^ kx_c[255:128];
          state_d = DONE;
        end else begin
          if (rnd_q[0]) begin
            s_d = mc_c ^ k_q[127:0];
          end else begin
            s_d = mc_c ^ kx_c[255:128];
            k_d = kx_c;
            j_d = j_q + J_W'(1);
          end
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == ROUND) || (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = s_q;
  assign busy      = busy_q;

endmodule
